// File: rtl/mem_rmw_store.sv
// mem_rmw_store: read-modify-write store engine between the CPU store path
// and a word-wide, word-addressed data memory.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   reqValid/reqReady           store request handshake (reqReady = idle)
//   reqAddr, reqData, reqMode   byte address, right-aligned data, size code
//   respValid/respFault         one-cycle completion pulse and its fault flag
//   memReq, memWe, memAddr      memory request, write enable, word address
//   memWdata                    merged write data
//   memGnt                      memory accepts the current request
//   memRvalid, memRdata         read data return
module mem_rmw_store #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               reqValid,
  output logic                               reqReady,
  input  logic [ADDR_W-1:0]                  reqAddr,
  input  logic [WORD_W-1:0]                  reqData,
  input  logic [1:0]                         reqMode,
  output logic                               respValid,
  output logic                               respFault,
  output logic                               memReq,
  output logic                               memWe,
  output logic [ADDR_W-$clog2(WORD_W/8)-1:0] memAddr,
  output logic [WORD_W-1:0]                  memWdata,
  input  logic                               memGnt,
  input  logic                               memRvalid,
  input  logic [WORD_W-1:0]                  memRdata
);

  localparam int LANES = WORD_W / 8;
  localparam int OFF_W = $clog2(LANES);
  // Largest legal mode: its size equals the full memory word.
  localparam logic [1:0] MAX_MODE = 2'(OFF_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_RESP
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-OFF_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]         data_q, data_d;   // store data already shifted into its lanes
  logic [LANES-1:0]          lane_q, lane_d;   // byte lanes written by the store
  logic [WORD_W-1:0]         wdata_q, wdata_d;
  logic                      fault_q, fault_d;

  logic [OFF_W-1:0]          req_off;
  logic                      req_misalign;
  logic                      req_fault;
  logic                      req_full;
  logic [LANES-1:0]          req_lanes;
  logic [WORD_W-1:0]         merged;

  assign req_off = reqAddr[OFF_W-1:0];

  // Request decode: alignment requires the low reqMode offset bits to be zero.
  always_comb begin
    req_misalign = 1'b0;
    req_lanes    = '0;
    for (int unsigned i = 0; i < OFF_W; i++) begin
      if (i < 32'(reqMode) && req_off[i]) req_misalign = 1'b1;
    end
    for (int unsigned i = 0; i < LANES; i++) begin
      req_lanes[i] = (i >= 32'(req_off)) && (i < 32'(req_off) + (32'd1 << reqMode));
    end
    req_fault = (reqMode > MAX_MODE) || req_misalign;
    req_full  = (reqMode == MAX_MODE);
  end

  // Lane merge of latched store data over the returned memory word.
  always_comb begin
    merged = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      merged[8*i +: 8] = lane_q[i] ? data_q[8*i +: 8] : memRdata[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    lane_d  = lane_q;
    wdata_d = wdata_q;
    fault_d = fault_q;
    unique case (state_q)
      S_IDLE: begin
        if (reqValid) begin
          addr_d  = reqAddr[ADDR_W-1:OFF_W];
          data_d  = reqData << {req_off, 3'b000};
          lane_d  = req_lanes;
          fault_d = req_fault;
          if (req_fault) begin
            state_d = S_RESP;
          end else if (req_full) begin
            wdata_d = reqData;
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ:  if (memGnt) state_d = S_WAIT;
      S_WAIT: begin
        if (memRvalid) begin
          wdata_d = merged;
          state_d = S_WRITE;
        end
      end
      S_WRITE: if (memGnt) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      lane_q  <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      fault_q <= fault_d;
    end
  end

  // Outputs decode registered state only; they hold steady while a grant is pending.
  assign reqReady  = (state_q == S_IDLE);
  assign respValid = (state_q == S_RESP);
  assign respFault = (state_q == S_RESP) && fault_q;
  assign memReq    = (state_q == S_READ) || (state_q == S_WRITE);
  assign memWe     = (state_q == S_WRITE);
  assign memAddr   = addr_q;
  assign memWdata  = wdata_q;

endmodule

// File: doc/mem_rmw_store.md
Name: mem_rmw_store

Overview:
- Parametrised read-modify-write store engine between the CPU store path and a word-wide, word-addressed data memory.
- Accepts byte, halfword, word or doubleword stores at byte addresses.
- For sub-word stores it reads the containing memory word, merges the new lanes and writes the word back. Full-width stores are written directly.
- Misaligned accesses and illegal modes fault cleanly instead of corrupting adjacent bytes.

Parameters:
- WORD_W, 32: memory word width in bits. Legal values are 32 and 64. LANES = WORD_W/8; OFF_W = log2(LANES).
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- reqValid  in  1  store request valid.
- reqReady  out  1  engine idle; request accepted when reqValid && reqReady.
- reqAddr  in  ADDR_W  byte address.
- reqData  in  WORD_W  store data, right-aligned (low bytes significant).
- reqMode  in  2  0=byte, 1=half, 2=word, 3=dword. Mode 3 is legal only when WORD_W=64.
- respValid  out  1  one-cycle completion pulse.
- respFault  out  1  qualifies respValid; 1 = misaligned or illegal mode, no memory write done.
- memReq  out  1  memory request valid.
- memWe  out  1  1 = write, 0 = read.
- memAddr  out  ADDR_W-OFF_W  word address = reqAddr[ADDR_W-1:OFF_W].
- memWdata  out  WORD_W  merged write data.
- memGnt  in  1  memory accepts the request this cycle.
- memRvalid  in  1  read data valid, at least one cycle after grant.
- memRdata  in  WORD_W  read data.

Behaviour:
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - reqReady=1 once out of reset. respValid, respFault, memReq and memWe = 0. memAddr and memWdata = 0.
  - Reset mid-operation abandons the transaction with no response; an outstanding memRvalid arriving afterwards is ignored.
- Size and alignment:
  - size = 1<<reqMode bytes; off = reqAddr[OFF_W-1:0].
  - Fault if reqMode encodes size > LANES, or off is not a multiple of size.
- Merge:
  - Result byte i = reqData byte (i-off) for off <= i < off+size; otherwise memRdata byte i.
  - Full-width store (size == LANES): merged word = reqData; no read is issued.
- Request handling: the request is latched on the handshake, so input changes afterwards have no effect.
- States:
  - IDLE: reqReady=1. On handshake: fault -> RESP with the fault flag set; full-width -> WRITE; otherwise -> READ.
  - READ: memReq=1, memWe=0, memAddr valid. On memGnt -> WAIT.
  - WAIT: memReq=0. On memRvalid, latch the merged word -> WRITE. memRvalid in any other state is ignored.
  - WRITE: memReq=1, memWe=1, memWdata = merged word. On memGnt -> RESP.
  - RESP: respValid=1 for exactly one cycle; respFault = latched fault flag; -> IDLE. There is no response backpressure.
- Memory handshake:
  - memReq, memWe, memAddr and memWdata stay stable while memReq && !memGnt.
  - A grant in the same cycle the request is first raised is legal.
- Latency, handshake at edge T, grant immediate, read data the cycle after grant:
  - Full-width: WRITE during T+1, respValid during T+2.
  - Sub-word: READ T+1, WAIT T+2 (memRvalid), WRITE T+3, respValid T+4.
  - Fault: respValid during T+1, no memReq ever raised.
- A new request is accepted no earlier than the cycle after RESP.
- reqReady is combinationally decoded from state; there are no combinational paths from req* inputs to outputs.

Test Plan:
- WORD_W=32, byte store, reqAddr=0x1003, reqData=0xAB, memRdata=0x11223344 -> read of word 0x400, write memWdata=0xAB223344, respValid with respFault=0 at T+4.
- WORD_W=32, half store, reqAddr=0x2002, reqData=0xBEEF, memRdata=0xDEADC0DE -> memWdata=0xBEEFC0DE. Repeat at addr 0x2000 -> 0xDEADBEEF.
- Misaligned half at 0x3001, and word at 0x3002 -> respValid with respFault=1 at T+1; memReq stays 0.
- WORD_W=64, dword store, reqAddr=0x8, data 0x0123456789ABCDEF -> no read; single write to word addr 1 with that data; response at T+2. Mode 3 with WORD_W=32 -> fault.
- memGnt held low for 5 cycles in READ and again in WRITE -> memReq/memAddr/memWdata stable throughout; reqReady=0; exactly one respValid.
- rst_n asserted in WAIT, then a late memRvalid -> no write issued, no respValid; next request completes normally.
